// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - in-order instruction issue queue feeding a Tomasulo core
// Circular FIFO; the head issues when its class (ARITH / LS) is not stalled, illegal opcodes are dropped.
module instr_issue_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_valid,
   input  logic [31:0]                fetch_instr,
   output logic                       fetch_ready,
   input  logic                       A_stall,
   input  logic                       LS_stall,
   input  logic                       flush,
   output logic [31:0]                instr,
   output logic                       issue_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       illegal,
   output logic [CNT_W-1:0]           issued_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      CLS_ARITH,
      CLS_LS,
      CLS_ILLEGAL
   } instr_class_t;

   logic [31:0]    mem [DEPTH];
   logic [PW-1:0]  head;
   logic [PW-1:0]  tail;
   logic [CW-1:0]  count_q;
   logic [31:0]    head_word;
   instr_class_t   head_class;
   logic           empty;
   logic           issue;
   logic           drop;
   logic           pop;
   logic           push;

   assign head_word = mem[head];
   assign empty     = (count_q == '0);

   always_comb begin
      head_class = CLS_ILLEGAL;
      case (head_word[6:0])
         7'b0000011, 7'b0100011: head_class = CLS_LS;
         7'b0110011, 7'b0010011: head_class = CLS_ARITH;
         default:                head_class = CLS_ILLEGAL;
      endcase
   end

   // Stalls gate only their own class, so a stalled head blocks everything behind it.
   assign issue = !empty && !flush &&
                  (((head_class == CLS_ARITH) && !A_stall) ||
                   ((head_class == CLS_LS)    && !LS_stall));
   assign drop  = !empty && !flush && (head_class == CLS_ILLEGAL);
   assign pop   = issue || drop;

   assign fetch_ready = (count_q < CW'(DEPTH));
   assign push        = fetch_valid && fetch_ready && !flush;

   assign instr       = issue ? head_word : 32'h0;
   assign issue_valid = issue;
   assign count       = count_q;

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[tail] <= fetch_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count_q    <= '0;
         illegal    <= 1'b0;
         issued_cnt <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            tail <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         if (issue) begin
            issued_cnt <= issued_cnt + 1'b1;
         end
         if (drop) begin
            illegal <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - self-checking bench for instr_issue_queue
// Directed scenarios followed by random traffic, all checked against a queue-based reference model.
module tb_instr_issue_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   localparam logic [31:0] ADD  = 32'h002081B3;
   localparam logic [31:0] ADDI = 32'h00108093;
   localparam logic [31:0] LW   = 32'h0000A103;
   localparam logic [31:0] SW   = 32'h0020A023;
   localparam logic [31:0] JAL  = 32'h0000006F;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    fetch_valid;
   logic [31:0]             fetch_instr;
   logic                    fetch_ready;
   logic                    A_stall;
   logic                    LS_stall;
   logic                    flush;
   logic [31:0]             instr;
   logic                    issue_valid;
   logic [$clog2(DEPTH):0]  count;
   logic                    illegal;
   logic [CNT_W-1:0]        issued_cnt;

   always #5 clk = ~clk;

   instr_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_ready (fetch_ready),
      .A_stall     (A_stall),
      .LS_stall    (LS_stall),
      .flush       (flush),
      .instr       (instr),
      .issue_valid (issue_valid),
      .count       (count),
      .illegal     (illegal),
      .issued_cnt  (issued_cnt)
   );

   logic [31:0] mq [$];
   int          m_issued;
   bit          m_illegal;
   int          checks;
   int          errors;

   // 0 = arithmetic, 1 = load/store, 2 = unsupported
   function automatic int cls_of(logic [31:0] w);
      case (w[6:0])
         7'b0000011, 7'b0100011: return 1;
         7'b0110011, 7'b0010011: return 0;
         default:                return 2;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(bit fv, logic [31:0] fi, bit as, bit ls, bit fl, bit rst);
      bit          can_issue;
      bit          do_push;
      int          c;
      logic [31:0] exp_instr;
      @(negedge clk);
      fetch_valid = fv;
      fetch_instr = fi;
      A_stall     = as;
      LS_stall    = ls;
      flush       = fl;
      reset       = rst;
      #1;
      c         = (mq.size() != 0) ? cls_of(mq[0]) : 2;
      can_issue = (mq.size() != 0) && !fl && ((c == 0 && !as) || (c == 1 && !ls));
      exp_instr = can_issue ? mq[0] : 32'h0;
      chk("count",       32'(count),       32'(mq.size()));
      chk("fetch_ready", 32'(fetch_ready), 32'(mq.size() < DEPTH));
      chk("instr",       instr,            exp_instr);
      chk("issue_valid", 32'(issue_valid), 32'(can_issue));
      chk("illegal",     32'(illegal),     32'(m_illegal));
      chk("issued_cnt",  32'(issued_cnt),  32'(m_issued % (1 << CNT_W)));
      if (rst) begin
         mq.delete();
         m_issued  = 0;
         m_illegal = 0;
      end else if (fl) begin
         mq.delete();
      end else begin
         do_push = fv && (mq.size() < DEPTH);
         if (mq.size() != 0) begin
            if (c == 2) begin
               m_illegal = 1;
               void'(mq.pop_front());
            end else if (can_issue) begin
               m_issued++;
               void'(mq.pop_front());
            end
         end
         if (do_push) mq.push_back(fi);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(bit as, bit ls);
      step(1'b0, 32'h0, as, ls, 1'b0, 1'b0);
   endtask

   logic [31:0] pool [6];

   initial begin
      checks = 0;
      errors = 0;
      m_issued = 0;
      m_illegal = 0;
      pool[0] = ADD; pool[1] = ADDI; pool[2] = LW; pool[3] = SW; pool[4] = JAL; pool[5] = 32'h0;
      reset = 1'b1; fetch_valid = 1'b0; fetch_instr = '0;
      A_stall = 1'b0; LS_stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);

      // empty after reset, then single add with one-cycle latency
      step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("add_count", 32'(count), 32'd1);
      idle(1'b0, 1'b0);
      chk("add_done_count",  32'(count),      32'd0);
      chk("add_done_issued", 32'(issued_cnt), 32'd1);

      // four lw with LS stalled fill the queue, then drain in order
      for (int i = 0; i < 4; i++) step(1'b1, LW | (32'(i) << 20), 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, SW, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("full_count", 32'(count), 32'd4);
      for (int i = 0; i < 5; i++) idle(1'b0, 1'b0);

      // stalled lw at head blocks a ready add behind it
      step(1'b1, LW, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, ADD, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);

      // jal is dropped, illegal sticks, following add issues
      step(1'b1, JAL, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("illegal_sticky", 32'(illegal), 32'd1);

      // flush with a concurrent push loses everything
      for (int i = 0; i < 3; i++) step(1'b1, SW, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, ADD, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("flush_count", 32'(count), 32'd0);
      idle(1'b0, 1'b0);

      // issued counter wraps after 2^CNT_W + 1 issues
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < (1 << CNT_W) + 1; i++) step(1'b1, ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b0);
      chk("wrap_issued", 32'(issued_cnt), 32'd1);

      // reset mid-stream with queued entries and illegal set
      step(1'b1, JAL, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, LW, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, SW, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("rst_count",   32'(count),       32'd0);
      chk("rst_illegal", 32'(illegal),     32'd0);
      chk("rst_issued",  32'(issued_cnt),  32'd0);
      chk("rst_ready",   32'(fetch_ready), 32'd1);
      idle(1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] w;
         w = pool[$urandom_range(0, 5)];
         if (w == 32'h0) w = $urandom;
         step(($urandom_range(0, 1) == 1), w,
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_issue_queue.md
INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning issued-instruction counter width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fetch_valid  input  1  upstream instruction word present.
REQ-006 SHALL have port fetch_instr  input  32  RV32 instruction word.
REQ-007 SHALL have port fetch_ready  output  1  queue accepts a word this cycle.
REQ-008 SHALL have port A_stall  input  1  arithmetic reservation stations full.
REQ-009 SHALL have port LS_stall  input  1  load/store stations or FIFO full.
REQ-010 SHALL have port flush  input  1  discard all queued instructions.
REQ-011 SHALL have port instr  output  32  word presented to the Tomasulo core; 32'h0 = bubble.
REQ-012 SHALL have port issue_valid  output  1  instr carries a real issue this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port illegal  output  1  sticky: unsupported opcode reached head.
REQ-015 SHALL have port issued_cnt  output  CNT_W  number of instructions issued, wrapping.

Function
REQ-016 SHALL implement a circular FIFO with head and tail pointers wrapping modulo DEPTH and an occupancy counter.
REQ-017 SHALL drive fetch_ready = (count < DEPTH); no bypass of a full queue.
REQ-018 SHALL push fetch_instr at tail on a rising edge when fetch_valid && fetch_ready && !flush.
REQ-019 SHALL classify the head opcode [6:0]: 0000011 and 0100011 -> LS class; 0110011 and 0010011 -> ARITH class; any other -> ILLEGAL class.
REQ-020 SHALL compute issue = (count != 0) && !flush && ((ARITH && !A_stall) || (LS && !LS_stall)).
REQ-021 SHALL drive, combinationally, instr = head entry and issue_valid = 1 when issue, else instr = 32'h0 and issue_valid = 0.
REQ-022 SHALL pop the head on the edge ending an issue cycle and increment issued_cnt by 1 (wraps at 2^CNT_W).
REQ-023 SHALL, when the head is ILLEGAL and !flush, pop it without issue (instr = 0, issue_valid = 0) and set illegal to 1.
REQ-024 SHALL hold the head entry unchanged for as many cycles as its class stall is high (in-order issue; no younger instruction overtakes it).
REQ-025 SHALL treat A_stall and LS_stall as registered core status; instr SHALL NOT feed back into them within the block.
REQ-026 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-027 SHALL give a minimum latency of one cycle: a word pushed into an empty queue appears on instr on the following cycle.
REQ-028 SHALL, on flush, clear count to 0 and set head = tail = 0 at the edge; flush overrides push and pop in that cycle; illegal and issued_cnt are unaffected.
REQ-029 SHALL keep count within 0..DEPTH at all times; pop on empty and push on full are impossible by construction.

Reset
REQ-030 SHALL, with reset high at a rising edge, set head, tail and count to 0, illegal to 0 and issued_cnt to 0; reset overrides flush, push and pop.
REQ-031 SHALL, while the queue is empty after reset, drive instr = 32'h0, issue_valid = 0 and fetch_ready = 1.
REQ-032 SHALL, when reset is asserted mid-stream, discard all queued entries; there are no residual issues after release.

Verification
REQ-033 SHALL pass: push add x3,x1,x2 (32'h002081B3) into an empty queue with stalls low -> next cycle instr = 32'h002081B3, issue_valid = 1, then count = 0 and issued_cnt = 1.
REQ-034 SHALL pass: four lw pushed with LS_stall = 1 -> count = 4, fetch_ready = 0, instr = 0; after LS_stall drops, one lw issues per cycle in push order.
REQ-035 SHALL pass: head is lw with LS_stall = 1 and the next entry is add with A_stall = 0 -> add does not issue until lw has issued.
REQ-036 SHALL pass: push 32'h0000006F (jal) -> dropped without issue, illegal = 1 and stays 1; the following add issues normally.
REQ-037 SHALL pass: three entries queued, flush together with fetch_valid -> next cycle count = 0, the pushed word is lost, instr = 0.
REQ-038 SHALL pass: 2^CNT_W + 1 issues -> issued_cnt = 1; reset mid-operation -> all outputs return to their reset values at the next edge.
